// File: rtl/duty_update_sequencer.sv
// rtl/duty_update_sequencer.sv - three-phase duty sequencer: frame check, soft-start, shift flags, gate enable
// Optional build macro DUTY_SLEW_LIMIT_EN: RUN duties slew toward target by at most SLEW_MAX per update.
module duty_update_sequencer #(
  parameter int DUTY_W      = 9,
  parameter int DUTY_MAX    = 500,
  parameter int DUTY_MID    = 250,
  parameter int BAND        = 100,
  parameter int ARM_UPDATES = 16,
  parameter int SPI_TIMEOUT = 8
`ifdef DUTY_SLEW_LIMIT_EN
  , parameter int SLEW_MAX  = 32
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3*DUTY_W-1:0] spi_duty,
  input  logic                spi_valid,
  input  logic                update,
  input  logic                pwm_req,
  input  logic                fault_clr,
  output logic [3*DUTY_W-1:0] dpwm_duty,
  output logic                shflag_b,
  output logic                shflag_c,
  output logic                pwm_en,
  output logic [2:0]          state,
  output logic [1:0]          fault_code
);
  localparam int FW    = 3 * DUTY_W;
  localparam int DW1   = DUTY_W + 1;
  localparam int PW    = DUTY_W + 6;
  localparam int ARM_W = $clog2(ARM_UPDATES + 1);
  localparam int TMO_W = $clog2(SPI_TIMEOUT + 1);
  localparam logic [FW-1:0] MID3 = {3{DUTY_W'(DUTY_MID)}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ARM = 3'd1, S_SOFT = 3'd2, S_RUN = 3'd3, S_FAULT = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             req_meta_q, req_s_q;
  logic [FW-1:0]    target_q, target_d, duty_q, duty_d;
  logic             shb_q, shb_d, shc_q, shc_d, pwm_en_q, pwm_en_d;
  logic [1:0]       fault_q, fault_d;
  logic [4:0]       k_q, k_d;
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d, arm_next;
  logic [TMO_W-1:0] tmo_q, tmo_d, tmo_next;
  logic             got_frame_q, got_frame_d;
  logic             in_range;
  logic [FW-1:0]    ramp_duty, run_duty;

  // MID + ((target - MID) * k) >>> 4, with k = 16 reproducing target exactly
  function automatic logic [DUTY_W-1:0] ramp(input logic [DUTY_W-1:0] t, input logic [4:0] k);
    logic signed [DW1-1:0] diff;
    logic signed [PW-1:0]  prod;
    logic signed [PW-1:0]  scaled;
    diff   = $signed({1'b0, t}) - $signed(DW1'(DUTY_MID));
    prod   = PW'(diff) * $signed({{(PW-5){1'b0}}, k});
    scaled = prod >>> 4;
    ramp   = DUTY_W'(scaled + $signed(PW'(DUTY_MID)));
  endfunction

`ifdef DUTY_SLEW_LIMIT_EN
  function automatic logic [DUTY_W-1:0] slew(input logic [DUTY_W-1:0] t, input logic [DUTY_W-1:0] cur);
    logic signed [DW1-1:0] diff;
    logic signed [DW1-1:0] step;
    diff = $signed({1'b0, t}) - $signed({1'b0, cur});
    if (diff > $signed(DW1'(SLEW_MAX)))       step = $signed(DW1'(SLEW_MAX));
    else if (diff < -$signed(DW1'(SLEW_MAX))) step = -$signed(DW1'(SLEW_MAX));
    else                                      step = diff;
    slew = DUTY_W'($signed({1'b0, cur}) + step);
  endfunction
`endif

  function automatic logic region(input logic [DUTY_W-1:0] x);
    int q;
    q      = int'(x) / BAND;
    region = q[0];
  endfunction

  always_comb begin
    in_range  = 1'b1;
    ramp_duty = '0;
    run_duty  = '0;
    for (int i = 0; i < 3; i++) begin
      if (int'(spi_duty[i*DUTY_W +: DUTY_W]) > DUTY_MAX) in_range = 1'b0;
      ramp_duty[i*DUTY_W +: DUTY_W] = ramp(target_q[i*DUTY_W +: DUTY_W], k_q);
`ifdef DUTY_SLEW_LIMIT_EN
      run_duty[i*DUTY_W +: DUTY_W] = slew(target_q[i*DUTY_W +: DUTY_W], duty_q[i*DUTY_W +: DUTY_W]);
`else
      run_duty[i*DUTY_W +: DUTY_W] = target_q[i*DUTY_W +: DUTY_W];
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    duty_d      = duty_q;
    fault_d     = fault_q;
    k_d         = k_q;
    arm_cnt_d   = arm_cnt_q;
    got_frame_d = got_frame_q;
    tmo_d       = tmo_q;
    arm_next    = (arm_cnt_q == ARM_W'(ARM_UPDATES)) ? arm_cnt_q : arm_cnt_q + 1'b1;
    tmo_next    = tmo_q + 1'b1;

    // an out-of-range frame never reaches the target register
    if (spi_valid && in_range) target_d = spi_duty;

    case (state_q)
      S_IDLE: begin
        duty_d      = MID3;
        k_d         = '0;
        arm_cnt_d   = '0;
        got_frame_d = 1'b0;
        tmo_d       = '0;
        if (req_s_q) state_d = S_ARM;
      end
      S_ARM: begin
        duty_d = MID3;
        if (!req_s_q) begin
          state_d = S_IDLE;
        end else begin
          if (spi_valid && in_range) got_frame_d = 1'b1;
          if (update) begin
            arm_cnt_d = arm_next;
            if (arm_next == ARM_W'(ARM_UPDATES) && got_frame_q) begin
              state_d = S_SOFT;
              k_d     = '0;
              tmo_d   = '0;
            end
          end
        end
      end
      S_SOFT, S_RUN: begin
        if (spi_valid)   tmo_d = '0;
        else if (update) tmo_d = tmo_next;
        if (spi_valid && !in_range) begin
          state_d = S_FAULT;
          fault_d = 2'd2;
          duty_d  = MID3;
        end else if (!spi_valid && update && tmo_next == TMO_W'(SPI_TIMEOUT)) begin
          state_d = S_FAULT;
          fault_d = 2'd1;
          duty_d  = MID3;
        end else if (!req_s_q) begin
          state_d = S_IDLE;
          duty_d  = MID3;
        end else if (update) begin
          if (state_q == S_SOFT) begin
            duty_d = ramp_duty;
            k_d    = k_q + 1'b1;
            if (k_q == 5'd16) state_d = S_RUN;
          end else begin
            duty_d = run_duty;
          end
        end
      end
      default: begin
        duty_d = MID3;
        if (fault_clr && !req_s_q) begin
          state_d = S_IDLE;
          fault_d = 2'd0;
        end
      end
    endcase

    shb_d    = region(duty_d[2*DUTY_W +: DUTY_W]) ^ region(duty_d[DUTY_W +: DUTY_W]);
    shc_d    = region(duty_d[2*DUTY_W +: DUTY_W]) ^ region(duty_d[0 +: DUTY_W]);
    pwm_en_d = (state_d == S_SOFT) || (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_meta_q  <= 1'b0;
      req_s_q     <= 1'b0;
      state_q     <= S_IDLE;
      target_q    <= MID3;
      duty_q      <= MID3;
      shb_q       <= 1'b0;
      shc_q       <= 1'b0;
      pwm_en_q    <= 1'b0;
      fault_q     <= 2'd0;
      k_q         <= '0;
      arm_cnt_q   <= '0;
      tmo_q       <= '0;
      got_frame_q <= 1'b0;
    end else begin
      req_meta_q  <= pwm_req;
      req_s_q     <= req_meta_q;
      state_q     <= state_d;
      target_q    <= target_d;
      duty_q      <= duty_d;
      shb_q       <= shb_d;
      shc_q       <= shc_d;
      pwm_en_q    <= pwm_en_d;
      fault_q     <= fault_d;
      k_q         <= k_d;
      arm_cnt_q   <= arm_cnt_d;
      tmo_q       <= tmo_d;
      got_frame_q <= got_frame_d;
    end
  end

  assign dpwm_duty  = duty_q;
  assign shflag_b   = shb_q;
  assign shflag_c   = shc_q;
  assign pwm_en     = pwm_en_q;
  assign state      = state_q;
  assign fault_code = fault_q;
endmodule

// File: tb/tb_duty_update_sequencer.sv
// tb/tb_duty_update_sequencer.sv - directed bench for duty_update_sequencer
module tb_duty_update_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic [26:0] spi_duty;
  logic        spi_valid, update, pwm_req, fault_clr;
  logic [26:0] dpwm_duty;
  logic        shflag_b, shflag_c, pwm_en;
  logic [2:0]  state;
  logic [1:0]  fault_code;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  duty_update_sequencer dut (
    .clk(clk), .rst(rst), .spi_duty(spi_duty), .spi_valid(spi_valid), .update(update),
    .pwm_req(pwm_req), .fault_clr(fault_clr), .dpwm_duty(dpwm_duty), .shflag_b(shflag_b),
    .shflag_c(shflag_c), .pwm_en(pwm_en), .state(state), .fault_code(fault_code)
  );

  function automatic logic [26:0] d3(input int a, input int b, input int c);
    return {a[8:0], b[8:0], c[8:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int a, input int b, input int c);
    spi_duty  = d3(a, b, c);
    spi_valid = 1'b1;
    tick();
    spi_valid = 1'b0;
  endtask

  task automatic pulse_update();
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  task automatic frame_and_update(input int a, input int b, input int c);
    spi_duty  = d3(a, b, c);
    spi_valid = 1'b1;
    update    = 1'b1;
    tick();
    spi_valid = 1'b0;
    update    = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    for (int i = 0; i < budget && state !== s; i++) tick();
    check(tag, 32'(state), 32'(s));
  endtask

  task automatic go_run(input int a, input int b, input int c);
    pwm_req = 1'b1;
    wait_state("arm_entry", 3'd1, 8);
    send_frame(a, b, c);
    repeat (16) pulse_update();
    check("soft_entry", 32'(state), 32'd2);
    repeat (17) begin
      send_frame(a, b, c);
      pulse_update();
    end
    check("run_entry", 32'(state), 32'd3);
  endtask

  task automatic clear_fault(input int code);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("clr_ignored_state", 32'(state), 32'd4);
    check("clr_ignored_code", 32'(fault_code), 32'(code));
    pwm_req = 1'b0;
    repeat (3) tick();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("clr_idle_state", 32'(state), 32'd0);
    check("clr_idle_code", 32'(fault_code), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_settle;
    int slew_a[7];
    logic [26:0] exp_co;
    int lat;
`ifdef DUTY_SLEW_LIMIT_EN
    n_settle = 10;
    exp_co   = d3(152, 218, 318);
    slew_a   = '{132, 164, 196, 228, 260, 292, 300};
`else
    n_settle = 1;
    exp_co   = d3(200, 200, 200);
    slew_a   = '{300, 300, 300, 300, 300, 300, 300};
`endif
    rst = 1'b0; spi_duty = '0; spi_valid = 1'b0; update = 1'b0; pwm_req = 1'b0; fault_clr = 1'b0;
    repeat (3) tick();
    check("rst_duty", 32'(dpwm_duty), 32'(d3(250, 250, 250)));
    check("rst_pwm_en", 32'(pwm_en), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_fault", 32'(fault_code), 32'd0);
    check("rst_shflags", {30'd0, shflag_b, shflag_c}, 32'd0);
    rst = 1'b1;
    tick();

    // soft-start from ARM; a bad frame in ARM must not count as a received frame
    pwm_req = 1'b1;
    wait_state("t1_arm", 3'd1, 8);
    send_frame(501, 100, 100);
    repeat (16) pulse_update();
    check("t1_arm_no_frame", 32'(state), 32'd1);
    check("t1_arm_pwm_en", 32'(pwm_en), 32'd0);
    send_frame(400, 150, 50);
    pulse_update();
    check("t1_soft", 32'(state), 32'd2);
    check("t1_soft_pwm_en", 32'(pwm_en), 32'd1);
    for (int k = 0; k <= 16; k++) begin
      send_frame(400, 150, 50);
      pulse_update();
      check("t1_ramp_pwm_en", 32'(pwm_en), 32'd1);
      if (k == 0) check("t1_k0", 32'(dpwm_duty), 32'(d3(250, 250, 250)));
      if (k == 1) begin
        check("t1_k1", 32'(dpwm_duty), 32'(d3(259, 243, 237)));
        check("t1_k1_flags", {30'd0, shflag_b, shflag_c}, 32'd0);
      end
      if (k < 16) check("t1_still_soft", 32'(state), 32'd2);
    end
    check("t1_k16", 32'(dpwm_duty), 32'(d3(400, 150, 50)));
    check("t1_run", 32'(state), 32'd3);
    check("t1_k16_shb", 32'(shflag_b), 32'd1);
    check("t1_k16_shc", 32'(shflag_c), 32'd0);

    // RUN frame, shift flags
    send_frame(120, 250, 350);
    check("t2_hold", 32'(dpwm_duty), 32'(d3(400, 150, 50)));
    for (int i = 0; i < n_settle; i++) begin
      if (i > 0) send_frame(120, 250, 350);
      pulse_update();
    end
    check("t2_duty", 32'(dpwm_duty), 32'(d3(120, 250, 350)));
    check("t2_shb", 32'(shflag_b), 32'd1);
    check("t2_shc", 32'(shflag_c), 32'd0);
    check("t2_pwm_en", 32'(pwm_en), 32'd1);

    // frame coincident with update: old target first
    frame_and_update(200, 200, 200);
    check("t5_coinc_old", 32'(dpwm_duty), 32'(d3(120, 250, 350)));
    pulse_update();
    check("t5_coinc_new", 32'(dpwm_duty), 32'(exp_co));

    // timeout: a frame on the 7th update restarts the count
    send_frame(200, 200, 200);
    repeat (6) pulse_update();
    frame_and_update(200, 200, 200);
    repeat (7) pulse_update();
    check("t4_no_fault", 32'(state), 32'd3);
    pulse_update();
    check("t4_fault_state", 32'(state), 32'd4);
    check("t4_fault_code", 32'(fault_code), 32'd1);
    check("t4_pwm_en", 32'(pwm_en), 32'd0);
    check("t4_duty_mid", 32'(dpwm_duty), 32'(d3(250, 250, 250)));
    clear_fault(1);

    // range fault in RUN
    go_run(100, 100, 100);
    send_frame(100, 501, 100);
    check("t3_fault_state", 32'(state), 32'd4);
    check("t3_fault_code", 32'(fault_code), 32'd2);
    check("t3_pwm_en", 32'(pwm_en), 32'd0);
    check("t3_duty_mid", 32'(dpwm_duty), 32'(d3(250, 250, 250)));
    clear_fault(2);

    // pwm_req drop mid-SOFT
    pwm_req = 1'b1;
    wait_state("t5_arm", 3'd1, 8);
    send_frame(400, 150, 50);
    repeat (16) pulse_update();
    check("t5_soft", 32'(state), 32'd2);
    repeat (3) begin
      send_frame(400, 150, 50);
      pulse_update();
    end
    check("t5_k2", 32'(dpwm_duty), 32'(d3(268, 237, 225)));
    pwm_req = 1'b0;
    lat = 0;
    while (pwm_en === 1'b1 && lat < 3) begin
      tick();
      lat++;
    end
    check("t5_drop_pwm_en", 32'(pwm_en), 32'd0);
    check("t5_drop_state", 32'(state), 32'd0);
    check("t5_drop_duty", 32'(dpwm_duty), 32'(d3(250, 250, 250)));

    // RUN step toward a new A target
    go_run(100, 250, 250);
    for (int i = 0; i < 7; i++) begin
      if (i == 0) send_frame(300, 250, 250);
      pulse_update();
      check("t6_step_a", 32'(dpwm_duty[26:18]), 32'(slew_a[i]));
    end
    check("t6_shb", 32'(shflag_b), 32'd1);
    check("t6_run", 32'(state), 32'd3);

    // asynchronous reset mid-operation
    #2 rst = 1'b0;
    #1;
    check("arst_duty", 32'(dpwm_duty), 32'(d3(250, 250, 250)));
    check("arst_pwm_en", 32'(pwm_en), 32'd0);
    check("arst_state", 32'(state), 32'd0);
    check("arst_shflags", {30'd0, shflag_b, shflag_c}, 32'd0);
    check("arst_fault", 32'(fault_code), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
